calc_entry: RTL

CALC_ENTRY -- requirements
Module: calc_entry

---
 rtl/calc_entry.sv | 129 ++++++++++++
 1 files changed

// File: rtl/calc_entry.sv
// calc_entry: keypad calculator entry FSM with a 3-flop key synchronizer.
// Define CALC_ENTRY_DEBOUNCE_EN to accept presses only after DEBOUNCE_CYCLES stable-high cycles.
module calc_entry #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [4:0] tens_mem_1,
    output logic [4:0] ones_mem_1,
    output logic [4:0] tens_mem_2,
    output logic [4:0] ones_mem_2,
    output logic [2:0] num_state,
    output logic [4:0] arithmetic,
    output logic       key_ack
);
    typedef enum logic [1:0] {ENTER1 = 2'b00, ENTER2 = 2'b10, RESULT = 2'b11} state_t;
    localparam logic [4:0] BLANK = 5'd11;
    state_t     state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic [4:0] tens1_q, tens1_d, ones1_q, ones1_d, tens2_q, tens2_d, ones2_q, ones2_d;
    logic [1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [4:0] arith_q, arith_d, op_onehot;
    logic [3:0] op_idx;
    logic       ack_q, ack_d, press;

    // returns {tens, ones, count} after entering digit d; leading zeros and a third digit are dropped
    function automatic logic [11:0] enter_digit(input logic [4:0] tens, input logic [4:0] ones,
                                                input logic [1:0] cnt, input logic [3:0] d);
        if (cnt == 2'd0) return (d == 4'd0) ? {tens, ones, cnt} : {BLANK, 1'b0, d, 2'd1};
        if (cnt == 2'd1) return {ones, 1'b0, d, 2'd2};
        return {tens, ones, cnt};
    endfunction

    assign sync_d = {sync_q[1:0], key_valid};

`ifdef CALC_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    always_comb begin
        db_cnt_d = !sync_q[1] ? '0 : (db_cnt_q == CW'(DEBOUNCE_CYCLES)) ? db_cnt_q : db_cnt_q + 1'b1;
        press    = sync_q[1] && (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) db_cnt_q <= '0;
        else          db_cnt_q <= db_cnt_d;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign press = sync_q[1] & ~sync_q[2];
`endif

    assign op_idx    = key_code - 4'd10;
    assign op_onehot = 5'd1 << op_idx[1:0];

    always_comb begin
        state_d = state_q;
        tens1_d = tens1_q;
        ones1_d = ones1_q;
        cnt1_d  = cnt1_q;
        tens2_d = tens2_q;
        ones2_d = ones2_q;
        cnt2_d  = cnt2_q;
        arith_d = arith_q;
        ack_d   = press;
        if (press) begin
            if (key_code == 4'd15) begin
                state_d = ENTER1;
                {tens1_d, ones1_d, cnt1_d} = {BLANK, 5'd0, 2'd0};
                {tens2_d, ones2_d, cnt2_d} = {BLANK, 5'd0, 2'd0};
                arith_d = 5'b00001;
            end else if (key_code < 4'd10) begin
                if (state_q == ENTER2) begin
                    {tens2_d, ones2_d, cnt2_d} = enter_digit(tens2_q, ones2_q, cnt2_q, key_code);
                end else if (state_q == ENTER1) begin
                    {tens1_d, ones1_d, cnt1_d} = enter_digit(tens1_q, ones1_q, cnt1_q, key_code);
                end else begin
                    {tens1_d, ones1_d, cnt1_d} = enter_digit(BLANK, 5'd0, 2'd0, key_code);
                    {tens2_d, ones2_d, cnt2_d} = {BLANK, 5'd0, 2'd0};
                    state_d = ENTER1;
                end
            end else if (key_code < 4'd14) begin
                if (state_q == ENTER1) begin
                    arith_d = op_onehot;
                    {tens2_d, ones2_d, cnt2_d} = {BLANK, 5'd0, 2'd0};
                    state_d = ENTER2;
                end else if (state_q == ENTER2 && cnt2_q == 2'd0) begin
                    arith_d = op_onehot;
                end
            end else if (state_q == ENTER2) begin
                state_d = RESULT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 3'b111;
            state_q <= ENTER1;
            tens1_q <= BLANK;
            ones1_q <= 5'd0;
            cnt1_q  <= 2'd0;
            tens2_q <= BLANK;
            ones2_q <= 5'd0;
            cnt2_q  <= 2'd0;
            arith_q <= 5'b00001;
            ack_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            tens1_q <= tens1_d;
            ones1_q <= ones1_d;
            cnt1_q  <= cnt1_d;
            tens2_q <= tens2_d;
            ones2_q <= ones2_d;
            cnt2_q  <= cnt2_d;
            arith_q <= arith_d;
            ack_q   <= ack_d;
        end
    end

    assign tens_mem_1 = tens1_q;
    assign ones_mem_1 = ones1_q;
    assign tens_mem_2 = tens2_q;
    assign ones_mem_2 = ones2_q;
    assign num_state  = {1'b0, state_q};
    assign arithmetic = arith_q;
    assign key_ack    = ack_q;
endmodule
